// File: rtl/local_cycle_control_pkg.sv
// local_cycle_control_pkg: shared encodings for the k30p local bus-cycle terminator
package local_cycle_control_pkg;
  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;
  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_8    = 2'b10;
  localparam logic [1:0] DSACK_NONE = 2'b11;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_ACK  = 3'd2;
  localparam logic [2:0] ST_BERR = 3'd3;
  localparam logic [2:0] ST_END  = 3'd4;
  typedef enum logic [1:0] {DEV_RAM, DEV_ROM, DEV_SERIAL} dev_e;
  function automatic logic [1:0] dev_dsack(input dev_e d, input logic rom16);
    return d == DEV_RAM ? DSACK_32 : d == DEV_ROM ? (rom16 ? DSACK_16 : DSACK_32) : DSACK_8;
  endfunction
endpackage

// File: rtl/local_cycle_control_cycle_timer.sv
// local_cycle_control_cycle_timer: loadable wait-state down-counter with zero flag
module local_cycle_control_cycle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] value_i,
  output logic       zero_o
);
  logic [3:0] count_q;
  always_ff @(posedge clk)
    count_q <= rst ? 4'd0 : load_i ? value_i : count_q - {3'd0, count_q != 4'd0};
  assign zero_o = count_q == 4'd0;
endmodule

// File: rtl/local_cycle_control.sv
// local_cycle_control: wait-state insertion and DSACK/BERR termination for local 68030 peripherals
module local_cycle_control
  import local_cycle_control_pkg::*;
#(
  parameter int unsigned RAM_WAIT    = 1,
  parameter int unsigned ROM_WAIT    = 3,
  parameter int unsigned SERIAL_WAIT = 6,
  parameter int unsigned TIMEOUT     = 64,
  parameter bit          ROM_16BIT   = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_as,
  input  logic       cpu_ds,
  input  logic       request_ram,
  input  logic       request_rom,
  input  logic       request_serial,
  input  logic       request_vme,
  input  logic       request_unmapped,
  output logic [1:0] cpu_dsack,
  output logic       cpu_berr,
  output logic       serial_cs
);
  logic [2:0] state_q, state_d;
  dev_e       dev_q, dev_d, dev_sel;
  logic [6:0] tmo_q, tmo_d;
  logic [1:0] dsack_q, dsack_d;
  logic       berr_q, berr_d, cs_q, cs_d;
  logic [3:0] wait_sel;
  logic       local_req, load, wait_zero;
  assign local_req = !(request_ram & request_rom & request_serial);
  assign dev_sel   = !request_ram ? DEV_RAM : !request_rom ? DEV_ROM : DEV_SERIAL;
  assign wait_sel  = !request_ram ? 4'(RAM_WAIT) : !request_rom ? 4'(ROM_WAIT) : 4'(SERIAL_WAIT);
  assign load      = state_q == ST_IDLE && !cpu_as && request_unmapped && local_req;
  local_cycle_control_cycle_timer u_timer (
    .clk    (clock),
    .rst    (reset),
    .load_i (load),
    .value_i(wait_sel),
    .zero_o (wait_zero)
  );
  always_comb begin
    state_d = state_q;
    dev_d   = dev_q;
    tmo_d   = 7'd0;
    dsack_d = dsack_q;
    berr_d  = INACTIVE;
    cs_d    = cs_q;
    case (state_q)
      ST_IDLE: if (!cpu_as) begin
        if (!request_unmapped) state_d = ST_BERR;
        else if (local_req) begin
          state_d = ST_WAIT;
          dev_d   = dev_sel;
          cs_d    = dev_sel == DEV_SERIAL ? ACTIVE : INACTIVE;
        end
        else if (!request_vme) state_d = ST_END;
        else if (tmo_q == 7'(TIMEOUT - 1)) state_d = ST_BERR;
        else tmo_d = tmo_q + 7'd1;
      end
      ST_WAIT: if (cpu_as) begin
        state_d = ST_IDLE;
        cs_d    = INACTIVE;
      end else if (wait_zero && !cpu_ds) begin
        state_d = ST_ACK;
        dsack_d = dev_dsack(dev_q, ROM_16BIT);
      end
      ST_BERR: begin
        berr_d  = ACTIVE;
        state_d = ST_END;
      end
      ST_ACK, ST_END: if (cpu_as) begin
        state_d = ST_IDLE;
        dsack_d = DSACK_NONE;
        cs_d    = INACTIVE;
      end else state_d = ST_END;
      default: state_d = ST_END;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_END;
      dev_q   <= DEV_RAM;
      tmo_q   <= 7'd0;
      dsack_q <= DSACK_NONE;
      berr_q  <= INACTIVE;
      cs_q    <= INACTIVE;
    end else begin
      state_q <= state_d;
      dev_q   <= dev_d;
      tmo_q   <= tmo_d;
      dsack_q <= dsack_d;
      berr_q  <= berr_d;
      cs_q    <= cs_d;
    end
  end
  assign cpu_dsack = dsack_q;
  assign cpu_berr  = berr_q;
  assign serial_cs = cs_q;
endmodule
